uart_rx_core: RTL and testbench

Serial-to-parallel UART receiver: the receive-side counterpart of the TX write path.
- Synchronizes the asynchronous rx_in line, detects and validates the start bit, samples data/parity/stop at bit centres, and presents each byte on a valid/ready interface.
- Downstream is an RX FIFO or register interface.
- Frame format: 1 start bit, DATA_WIDTH data bits LSB-first, optional parity, 1 stop bit.

---
 rtl/uart_rx_core.sv | 156 +++++++++++++++
 tb/tb_uart_rx_core.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: synchronizer, bit-centre sampling FSM, valid/ready byte output
module uart_rx_core #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun,
    output logic                  busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_IDLE = 3'd5;

    logic                  sync_q;
    logic                  rx_s;
    logic [2:0]            state;
    logic [CW-1:0]         clk_cnt;
    logic [BW-1:0]         bit_idx;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  par_ok;
    logic                  bit_end;

    assign busy    = (state != IDLE);
    assign bit_end = (clk_cnt == FULL_CNT);

    // Two-flop synchronizer; resets to the idle (high) line level so reset release never looks like a start bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_q <= rx_in;
            rx_s   <= sync_q;
        end
    end

    // Frame FSM, bit timing, byte assembly and output handshake; error flags default low so they are single-cycle pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_ok     <= 1'b1;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_CNT) begin
                        clk_cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                            par_ok  <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        clk_cnt            <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == LAST_BIT) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        par_ok  <= (((^shift_reg) ^ rx_s) == (PARITY_ODD != 0));
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            state     <= WAIT_IDLE;
                        end else if (!par_ok) begin
                            parity_err <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            // Leaving at the stop-bit centre gives half a bit of slack to catch a back-to-back start.
                            state <= IDLE;
                            if (rx_valid && !rx_ready) begin
                                overrun <= 1'b1;
                            end else begin
                                rx_data  <= shift_reg;
                                rx_valid <= 1'b1;
                            end
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    clk_cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - scoreboard bench for uart_rx_core (plain and even-parity instances)
module tb_uart_rx_core;

    localparam int CPB = 16;

    localparam int K_BYTE = 0;
    localparam int K_FERR = 1;
    localparam int K_PERR = 2;
    localparam int K_OVR  = 3;

    typedef struct {
        int         dut;
        int         kind;
        logic [7:0] data;
    } ev_t;

    logic       clk;
    logic       rstn;
    logic       rx_a, rx_b;
    logic       rdy_a, rdy_b;
    logic [7:0] data_a, data_b;
    logic       val_a, val_b;
    logic       fe_a, fe_b, pe_a, pe_b, ov_a, ov_b, busy_a, busy_b;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
        .clk(clk), .rstn(rstn), .rx_in(rx_a), .rx_data(data_a), .rx_valid(val_a),
        .rx_ready(rdy_a), .frame_err(fe_a), .parity_err(pe_a), .overrun(ov_a), .busy(busy_a)
    );

    uart_rx_core #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_par (
        .clk(clk), .rstn(rstn), .rx_in(rx_b), .rx_data(data_b), .rx_valid(val_b),
        .rx_ready(rdy_b), .frame_err(fe_b), .parity_err(pe_b), .overrun(ov_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic push(input int dut, input int kind, input logic [7:0] data);
        ev_t e;
        e.dut  = dut;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic seen(input int dut, input int kind, input logic [7:0] data);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: dut %0d kind %0d data %0h, expected none", dut, kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e.dut != dut || e.kind != kind || (kind == K_BYTE && e.data !== data)) begin
                n_fail++;
                $display("FAIL event: got dut %0d kind %0d data %0h, expected dut %0d kind %0d data %0h",
                         dut, kind, data, e.dut, e.kind, e.data);
            end
        end
    endtask

    // Monitor: every accepted byte and every flag pulse is matched against the scoreboard queue.
    always @(negedge clk) begin
        if (rstn) begin
            if (val_a && rdy_a) seen(0, K_BYTE, data_a);
            if (fe_a)           seen(0, K_FERR, 8'h00);
            if (pe_a)           seen(0, K_PERR, 8'h00);
            if (ov_a)           seen(0, K_OVR,  8'h00);
            if (val_b && rdy_b) seen(1, K_BYTE, data_b);
            if (fe_b)           seen(1, K_FERR, 8'h00);
            if (pe_b)           seen(1, K_PERR, 8'h00);
            if (ov_b)           seen(1, K_OVR,  8'h00);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_bit(input int sel, input logic b);
        if (sel == 0) rx_a = b;
        else          rx_b = b;
        tick(CPB);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input bit use_par, input bit pbit, input bit stopb);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (use_par) drive_bit(sel, pbit);
        drive_bit(sel, stopb);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        int gap;
        logic [7:0] part;
        rstn  = 1'b1;
        rx_a  = 1'b1;
        rx_b  = 1'b1;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        #3 rstn = 1'b0;
        tick(3);
        chk("reset_valid", val_a, 0);
        chk("reset_data",  data_a, 0);
        chk("reset_flags", {fe_a, pe_a, ov_a}, 0);
        chk("reset_busy",  busy_a, 0);
        rstn = 1'b1;
        tick(5);

        // Single frame 0xA5 with latency measurement.
        push(0, K_BYTE, 8'hA5);
        fork
            send(0, 8'hA5, 0, 0, 1);
            begin
                cnt = 0;
                while (!val_a && cnt < 400) begin
                    @(negedge clk);
                    cnt++;
                end
                n_checks++;
                if (cnt < 150 || cnt > 160) begin
                    n_fail++;
                    $display("FAIL latency: got %0d cycles, expected 150..160", cnt);
                end
            end
        join
        tick(10);

        // Back-to-back 0x00 / 0xFF; busy gap between frames.
        push(0, K_BYTE, 8'h00);
        push(0, K_BYTE, 8'hFF);
        fork
            begin
                send(0, 8'h00, 0, 0, 1);
                send(0, 8'hFF, 0, 0, 1);
            end
            begin
                cnt = 0;
                while (!busy_a && cnt < 50) begin @(negedge clk); cnt++; end
                cnt = 0;
                while (busy_a && cnt < 300) begin @(negedge clk); cnt++; end
                gap = 0;
                while (!busy_a && gap < 40) begin @(negedge clk); gap++; end
                n_checks++;
                if (gap < 1 || gap > 8) begin
                    n_fail++;
                    $display("FAIL busy_gap: got %0d cycles, expected 1..8", gap);
                end
            end
        join
        tick(20);

        // Start-bit glitch: 5 cycles low.
        rx_a = 1'b0;
        tick(4);
        chk("glitch_busy_hi", busy_a, 1);
        tick(1);
        rx_a = 1'b1;
        tick(20);
        chk("glitch_busy_lo", busy_a, 0);
        chk("glitch_valid", val_a, 0);

        // Framing error then break held low.
        push(0, K_FERR, 8'h00);
        send(0, 8'h3C, 0, 0, 0);
        tick(40);
        chk("break_busy", busy_a, 1);
        chk("break_valid", val_a, 0);
        rx_a = 1'b1;
        tick(30);
        chk("break_idle", busy_a, 0);

        // Overrun: consumer stalled across two frames.
        rdy_a = 1'b0;
        push(0, K_OVR,  8'h00);
        push(0, K_BYTE, 8'h11);
        send(0, 8'h11, 0, 0, 1);
        send(0, 8'h22, 0, 0, 1);
        tick(20);
        chk("ovr_data", data_a, 8'h11);
        chk("ovr_valid", val_a, 1);
        rdy_a = 1'b1;
        tick(1);
        chk("ovr_drop_valid", val_a, 0);
        tick(10);

        // Even parity: bad then good parity on 0x07.
        push(1, K_PERR, 8'h00);
        send(1, 8'h07, 1, 0, 1);
        tick(10);
        chk("par_bad_valid", val_b, 0);
        push(1, K_BYTE, 8'h07);
        send(1, 8'h07, 1, 1, 1);
        tick(20);

        // Reset during data bit 4, then clean 0x5A.
        part = 8'hFF;
        drive_bit(0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(0, part[i]);
        rx_a = part[4];
        tick(CPB / 2);
        rstn = 1'b0;
        rx_a = 1'b1;
        tick(3);
        chk("rst_mid_valid", val_a, 0);
        chk("rst_mid_data",  data_a, 0);
        chk("rst_mid_flags", {fe_a, pe_a, ov_a}, 0);
        chk("rst_mid_busy",  busy_a, 0);
        rstn = 1'b1;
        tick(40);
        push(0, K_BYTE, 8'h5A);
        send(0, 8'h5A, 0, 0, 1);
        tick(40);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
